// File: rtl/dbg_pkg.sv
// Shared definitions for the MMIO debug port: run-state encoding, default
// mailbox addresses, the pass code and a saturating counter helper.
package dbg_pkg;

  // Run state as reported on the state output
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } dbg_state_t;

  // Default addresses of the console character port and the status mailbox
  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h0000_FFFC;
  localparam logic [31:0] DEFAULT_STATUS_ADDR  = 32'h0000_FFF8;

  // Value written to the status mailbox to report success
  localparam logic [31:0] PASS_CODE = 32'd1;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy. A push into an empty FIFO
// becomes visible on the following cycle (no bypass). A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
// The head reads as zero whenever the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;

  logic w_doPush;
  logic w_doPop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == DEPTH_CNT);
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);
  assign data_out = empty ? '0 : r_mem[r_rdPtr];

  // Pointers wrap explicitly at the last slot; occupancy tracks push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= (r_rdPtr == LAST_IDX) ? '0 : r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; a push presented during reset is discarded
  always_ff @(posedge clk) begin
    if (!reset && w_doPush) begin
      r_mem[r_wrPtr] <= data_in;
    end
  end

endmodule

// File: rtl/mmio_debug_port.sv
// Simulation/debug sideband snooping a CPU store bus. Stores to the console
// address queue characters for an external consumer; stores to the status
// mailbox end the run as PASS or FAIL. A run-cycle limit forces TIMEOUT.
// Terminal states are sticky until reset, and done reports that the run has
// ended and every queued character has been consumed.
module mmio_debug_port
  import dbg_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(DEFAULT_CONSOLE_ADDR),
  parameter logic [ADDR_W-1:0] STATUS_ADDR    = ADDR_W'(DEFAULT_STATUS_ADDR),
  parameter int                FIFO_DEPTH     = 16,
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic [15:0]       overflow_cnt,
  output logic [1:0]        state,
  output logic [DATA_W-2:0] fail_code,
  output logic [31:0]       cycle_cnt,
  output logic              done
);

  localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  dbg_state_t        r_state;
  dbg_state_t        w_nextState;
  logic [31:0]       r_cycleCnt;
  logic [15:0]       r_overflowCnt;
  logic [DATA_W-2:0] r_failCode;
  logic              r_done;

  logic              w_consoleStore;
  logic              w_statusStore;
  logic              w_statusPass;
  logic              w_statusFail;
  logic              w_timeoutHit;
  logic              w_pop;
  logic              w_drop;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic [7:0]        w_fifoData;
  logic              w_inRun;
  logic              w_captureFail;

  // Address decode of the snooped store bus
  assign w_consoleStore = memwrite && (dataadr == CONSOLE_ADDR);
  assign w_statusStore  = memwrite && (dataadr == STATUS_ADDR);
  assign w_statusPass   = w_statusStore && (writedata == DATA_W'(PASS_CODE));
  assign w_statusFail   = w_statusStore && (writedata != '0) && !w_statusPass;
  assign w_timeoutHit   = TIMEOUT_EN && (r_cycleCnt == TIMEOUT_LAST);

  // Consumer handshake; a character is dropped only if no slot frees this cycle
  assign w_pop  = char_valid && char_ready;
  assign w_drop = w_consoleStore && w_fifoFull && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_charFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_consoleStore),
    .data_in  (writedata[7:0]),
    .pop      (w_pop),
    .data_out (w_fifoData),
    .full     (w_fifoFull),
    .empty    (w_fifoEmpty)
  );

  assign char_valid   = !w_fifoEmpty;
  assign char_data    = char_valid ? w_fifoData : 8'd0;
  assign overflow_cnt = r_overflowCnt;
  assign state        = r_state;
  assign fail_code    = r_failCode;
  assign cycle_cnt    = r_cycleCnt;
  assign done         = r_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: a status store outranks the timeout; terminal states hold
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_statusPass) begin
          w_nextState = ST_PASS;
        end else if (w_statusFail) begin
          w_nextState = ST_FAIL;
        end else if (w_timeoutHit) begin
          w_nextState = ST_TIMEOUT;
        end
      end
      default: w_nextState = r_state;
    endcase
  end

  // State-derived controls for the counters and the fail-code capture
  always_comb begin
    w_inRun       = (r_state == ST_RUN);
    w_captureFail = w_inRun && w_statusFail;
  end

  // Run-cycle counter, frozen once a terminal state is reached
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycleCnt <= '0;
    end else if (w_inRun) begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
    end
  end

  // Fail code keeps the mailbox value without its low bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_failCode <= '0;
    end else if (w_captureFail) begin
      r_failCode <= writedata[DATA_W-1:1];
    end
  end

  // Saturating count of console characters lost to a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflowCnt <= '0;
    end else if (w_drop) begin
      r_overflowCnt <= satInc16(r_overflowCnt);
    end
  end

  // Done once the run has ended and nothing is queued or arriving
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state != ST_RUN) && w_fifoEmpty && !w_consoleStore;
    end
  end

endmodule

// File: tb/tb_mmio_debug_port.sv
// Directed bench for mmio_debug_port: console ordering and latency, overflow
// with pointer wrap, full-FIFO push/pop, status decode, timeout priority and
// mid-run reset.
module tb_mmio_debug_port;
  import dbg_pkg::*;

  localparam logic [31:0] CON = 32'h0000_FFFC;
  localparam logic [31:0] STA = 32'h0000_FFF8;
  localparam logic [31:0] OTHER = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic [15:0] overflow_cnt;
  logic [1:0]  state;
  logic [30:0] fail_code;
  logic [31:0] cycle_cnt;
  logic        done;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  mmio_debug_port #(
    .DATA_W         (32),
    .ADDR_W         (32),
    .CONSOLE_ADDR   (CON),
    .STATUS_ADDR    (STA),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .char_valid   (char_valid),
    .char_data    (char_data),
    .char_ready   (char_ready),
    .overflow_cnt (overflow_cnt),
    .state        (state),
    .fail_code    (fail_code),
    .cycle_cnt    (cycle_cnt),
    .done         (done)
  );

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bus cycle, clock it in, then release the store strobe
  task automatic applyStimulus(input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic rdy);
    memwrite   = we;
    dataadr    = adr;
    writedata  = dat;
    char_ready = rdy;
    tick();
    memwrite   = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'd0, 32'd0, rdy);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    memwrite   = 1'b0;
    dataadr    = '0;
    writedata  = '0;
    char_ready = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset      = 1'b0;
  endtask

  initial begin
    // Reset values
    resetDut();
    checkOutput("rst_state", state, ST_RUN);
    checkOutput("rst_cycle", cycle_cnt, 0);
    checkOutput("rst_valid", char_valid, 0);
    checkOutput("rst_data", char_data, 0);
    checkOutput("rst_ovf", overflow_cnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_failcode", fail_code, 0);

    // Ordering and latency: 'H' then 'i' with the consumer always ready
    applyStimulus(1'b1, CON, 32'h48, 1'b1);
    checkOutput("ord_valid1", char_valid, 1);
    checkOutput("ord_data_H", char_data, 8'h48);
    applyStimulus(1'b1, CON, 32'h69, 1'b1);
    checkOutput("ord_valid2", char_valid, 1);
    checkOutput("ord_data_i", char_data, 8'h69);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    checkOutput("ord_empty", char_valid, 0);
    checkOutput("ord_data0", char_data, 0);
    checkOutput("ord_ovf", overflow_cnt, 0);
    checkOutput("ord_cycle", cycle_cnt, 3);

    // Overflow: 18 stores into 16 slots, then drain across the wrap
    resetDut();
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, CON, 32'h41 + i, 1'b0);
    checkOutput("ovf_cnt", overflow_cnt, 2);
    checkOutput("ovf_valid", char_valid, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    checkOutput("ovf_hold_A", char_data, 8'h41);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), char_data, 8'h41 + i);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    end
    checkOutput("ovf_drained", char_valid, 0);
    checkOutput("ovf_cnt_end", overflow_cnt, 2);

    // Full FIFO: a store coinciding with a pop is kept
    resetDut();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, CON, 32'h61 + i, 1'b0);
    checkOutput("full_ovf0", overflow_cnt, 0);
    applyStimulus(1'b1, CON, 32'h5A, 1'b1);
    checkOutput("full_pp_ovf", overflow_cnt, 0);
    checkOutput("full_pp_head", char_data, 8'h62);
    applyStimulus(1'b1, CON, 32'h59, 1'b0);
    checkOutput("full_still16", overflow_cnt, 1);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("full_drain%0d", i), char_data,
                  (i < 15) ? 64'(8'h62 + i) : 64'h5A);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    end
    checkOutput("full_drained", char_valid, 0);

    // PASS decode, ignored stores, frozen counter, done and refill
    resetDut();
    applyStimulus(1'b1, STA, 32'd0, 1'b0);
    checkOutput("pass_zero_ign", state, ST_RUN);
    applyStimulus(1'b1, OTHER, 32'd1, 1'b0);
    checkOutput("pass_other_st", state, ST_RUN);
    checkOutput("pass_other_v", char_valid, 0);
    idle(3, 1'b0);
    applyStimulus(1'b1, STA, 32'd1, 1'b0);
    checkOutput("pass_state", state, ST_PASS);
    checkOutput("pass_cycle", cycle_cnt, 6);
    checkOutput("pass_done_lat", done, 0);
    applyStimulus(1'b1, STA, 32'd3, 1'b0);
    checkOutput("pass_sticky", state, ST_PASS);
    checkOutput("pass_done", done, 1);
    checkOutput("pass_frozen", cycle_cnt, 6);
    applyStimulus(1'b1, CON, 32'h78, 1'b0);
    checkOutput("pass_refill_d", done, 0);
    checkOutput("pass_refill_c", char_data, 8'h78);

    // FAIL decode
    resetDut();
    applyStimulus(1'b1, STA, 32'h0000_000B, 1'b0);
    checkOutput("fail_state", state, ST_FAIL);
    checkOutput("fail_code", fail_code, 5);
    idle(1, 1'b0);
    checkOutput("fail_sticky", state, ST_FAIL);

    // Timeout after the 50th run cycle
    resetDut();
    idle(49, 1'b0);
    checkOutput("to_pre_state", state, ST_RUN);
    checkOutput("to_pre_cycle", cycle_cnt, 49);
    idle(1, 1'b0);
    checkOutput("to_state", state, ST_TIMEOUT);

    // Status store on the timeout cycle wins
    resetDut();
    idle(49, 1'b0);
    applyStimulus(1'b1, STA, 32'd1, 1'b0);
    checkOutput("to_prio_state", state, ST_PASS);

    // Reset mid-run discards queued characters and a same-cycle store
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, CON, 32'h31 + i, 1'b0);
    checkOutput("mrst_pre_v", char_valid, 1);
    checkOutput("mrst_pre_cyc", cycle_cnt, 3);
    reset     = 1'b1;
    memwrite  = 1'b1;
    dataadr   = CON;
    writedata = 32'h51;
    tick();
    reset     = 1'b0;
    memwrite  = 1'b0;
    checkOutput("mrst_valid", char_valid, 0);
    checkOutput("mrst_ovf", overflow_cnt, 0);
    checkOutput("mrst_state", state, ST_RUN);
    checkOutput("mrst_cycle", cycle_cnt, 0);
    idle(1, 1'b0);
    checkOutput("mrst_nostore", char_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
